// File: rtl/svo_vid_enc.sv
// Video timing encoder: buffers an AXI-Stream pixel feed, inserts blanking and
// sync, and emits a continuous raster that re-locks to the input frame on errors.
//
// state  | meaning
// RESYNC | discard non-SOF words, hold an SOF at the head until raster origin
// LOCKED | each active pixel pops one word; blanking never pops
module svo_vid_enc #(
  parameter int SVO_HOR_PIXELS     = 640,
  parameter int SVO_VER_PIXELS     = 480,
  parameter int SVO_BITS_PER_PIXEL = 18,
  parameter int H_FP               = 16,
  parameter int H_SYNC             = 96,
  parameter int H_BP               = 48,
  parameter int V_FP               = 10,
  parameter int V_SYNC             = 2,
  parameter int V_BP               = 33,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_axis_tvalid,
  output logic                          in_axis_tready,
  input  logic [SVO_BITS_PER_PIXEL-1:0] in_axis_tdata,
  input  logic                          in_axis_tuser,
  output logic                          out_axis_tvalid,
  input  logic                          out_axis_tready,
  output logic [SVO_BITS_PER_PIXEL-1:0] out_axis_tdata,
  output logic [3:0]                    out_axis_tuser,
  output logic                          locked,
  output logic                          underflow,
  output logic                          sof_err
);

  localparam int HTOT = SVO_HOR_PIXELS + H_FP + H_SYNC + H_BP;
  localparam int VTOT = SVO_VER_PIXELS + V_FP + V_SYNC + V_BP;
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int BPP  = SVO_BITS_PER_PIXEL;
  localparam int DW   = BPP + 1;

  localparam logic [HW-1:0] H_ACT    = HW'(SVO_HOR_PIXELS);
  localparam logic [HW-1:0] HS_START = HW'(SVO_HOR_PIXELS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(SVO_HOR_PIXELS + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST   = HW'(HTOT - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(SVO_VER_PIXELS);
  localparam logic [VW-1:0] VS_START = VW'(SVO_VER_PIXELS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(SVO_VER_PIXELS + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(VTOT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {
    ST_RESYNC = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [VW-1:0]   vcnt_q, vcnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            rdy_q, rdy_d;
  logic            tvalid_q, tvalid_d;
  logic [BPP-1:0]  tdata_q, tdata_d;
  logic [3:0]      tuser_q, tuser_d;
  logic            under_q, under_d;
  logic            sof_err_q, sof_err_d;

  logic [DW-1:0]   mem_q [FIFO_DEPTH];

  logic            adv;
  logic            push;
  logic            pop;
  logic            empty;
  logic [DW-1:0]   head;
  logic            head_sof;
  logic [BPP-1:0]  head_data;
  logic            active;
  logic            at_origin;
  logic            hsync;
  logic            vsync;
  logic [BPP-1:0]  pix;

  assign empty     = (count_q == '0);
  assign head      = mem_q[rd_ptr_q];
  assign head_sof  = head[DW-1];
  assign head_data = head[BPP-1:0];
  assign push      = in_axis_tvalid && rdy_q;
  assign adv       = !tvalid_q || out_axis_tready;

  assign active    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign at_origin = (hcnt_q == '0) && (vcnt_q == '0);
  assign hsync     = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
  assign vsync     = (vcnt_q >= VS_START) && (vcnt_q < VS_END);

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tuser_d   = tuser_q;
    under_d   = under_q;
    sof_err_d = sof_err_q;
    pop       = 1'b0;
    pix       = '0;

    if (adv) begin
      tvalid_d  = 1'b1;
      under_d   = 1'b0;
      sof_err_d = 1'b0;

      case (state_q)
        ST_RESYNC: begin
          if (!empty) begin
            if (!head_sof) begin
              pop = 1'b1;
            end else if (at_origin) begin
              pop     = 1'b1;
              pix     = head_data;
              state_d = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (active) begin
            if (empty) begin
              under_d = 1'b1;
              state_d = ST_RESYNC;
            end else if (head_sof != at_origin) begin
              // A misplaced SOF stays in the FIFO so it can lock the next frame.
              sof_err_d = 1'b1;
              state_d   = ST_RESYNC;
            end else begin
              pop = 1'b1;
              pix = head_data;
            end
          end
        end
        default: state_d = ST_RESYNC;
      endcase

      tdata_d = pix;
      tuser_d = {at_origin, !active, hsync, vsync};

      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    rdy_d = (count_d != FULL_CNT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_RESYNC;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rdy_q     <= 1'b0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tuser_q   <= '0;
      under_q   <= 1'b0;
      sof_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rdy_q     <= rdy_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tuser_q   <= tuser_d;
      under_q   <= under_d;
      sof_err_q <= sof_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_axis_tuser, in_axis_tdata};
    end
  end

  assign in_axis_tready  = rdy_q;
  assign out_axis_tvalid = tvalid_q;
  assign out_axis_tdata  = tdata_q;
  assign out_axis_tuser  = tuser_q;
  assign locked          = (state_q == ST_LOCKED);
  assign underflow       = under_q;
  assign sof_err         = sof_err_q;

endmodule

// File: tb/tb_svo_vid_enc.sv
// Bench for svo_vid_enc on a shrunken raster: a raster-position table plus
// randomized streams checked against a queue-based frame model.
module tb_svo_vid_enc;

  localparam int HOR = 8, VER = 4, BPP = 18;
  localparam int HFP = 2, HSY = 3, HBP = 2;
  localparam int VFP = 1, VSY = 2, VBP = 1;
  localparam int DEPTH = 16;
  localparam int HTOT = HOR + HFP + HSY + HBP;
  localparam int VTOT = VER + VFP + VSY + VBP;
  localparam int FRAME = HTOT * VTOT;
  localparam int NPIX = HOR * VER;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           in_axis_tvalid = 1'b0;
  logic           in_axis_tready;
  logic [BPP-1:0] in_axis_tdata = '0;
  logic           in_axis_tuser = 1'b0;
  logic           out_axis_tvalid;
  logic           out_axis_tready = 1'b1;
  logic [BPP-1:0] out_axis_tdata;
  logic [3:0]     out_axis_tuser;
  logic           locked;
  logic           underflow;
  logic           sof_err;

  always #5 clk = ~clk;

  svo_vid_enc #(
    .SVO_HOR_PIXELS(HOR), .SVO_VER_PIXELS(VER), .SVO_BITS_PER_PIXEL(BPP),
    .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn),
    .in_axis_tvalid(in_axis_tvalid), .in_axis_tready(in_axis_tready),
    .in_axis_tdata(in_axis_tdata), .in_axis_tuser(in_axis_tuser),
    .out_axis_tvalid(out_axis_tvalid), .out_axis_tready(out_axis_tready),
    .out_axis_tdata(out_axis_tdata), .out_axis_tuser(out_axis_tuser),
    .locked(locked), .underflow(underflow), .sof_err(sof_err)
  );

  typedef struct {
    logic           sof;
    logic [BPP-1:0] data;
  } word_t;

  typedef struct {
    int             beat;
    logic [3:0]     user;
    logic           lck;
    logic [BPP-1:0] data;
  } vec_t;

  word_t          q[$];
  bit             m_locked, m_valid, m_rdy;
  int             m_beat;
  logic [BPP-1:0] e_data;
  logic [3:0]     e_user;
  bit             e_under, e_sof;

  int             total = 0, bad = 0;
  int             n_under = 0, n_sof = 0, nsteps = 0;

  int             src_idx = 0;
  int             inject_at = -1;
  bit             src_en = 1'b0;
  logic [BPP-1:0] src_data = '0;

  task automatic model_reset();
    q.delete();
    m_locked = 0; m_valid = 0; m_rdy = 0; m_beat = 0;
    e_data = '0; e_user = '0; e_under = 0; e_sof = 0;
  endtask

  // Frame-level model: raster position comes from a beat index, FIFO is a queue.
  task automatic model_edge(output bit pushed);
    bit    adv, pop, act, at0, hs, vs;
    int    h, v;
    word_t w;
    adv    = !m_valid || out_axis_tready;
    pushed = in_axis_tvalid && m_rdy;
    pop    = 0;
    if (adv) begin
      h   = m_beat % HTOT;
      v   = m_beat / HTOT;
      act = (h < HOR) && (v < VER);
      at0 = (h == 0) && (v == 0);
      hs  = (h >= HOR + HFP) && (h < HOR + HFP + HSY);
      vs  = (v >= VER + VFP) && (v < VER + VFP + VSY);
      e_data = '0; e_under = 0; e_sof = 0;
      if (!m_locked) begin
        if (q.size() > 0) begin
          if (!q[0].sof) pop = 1;
          else if (at0) begin pop = 1; e_data = q[0].data; m_locked = 1; end
        end
      end else if (act) begin
        if (q.size() == 0) begin e_under = 1; m_locked = 0; end
        else if (q[0].sof != at0) begin e_sof = 1; m_locked = 0; end
        else begin pop = 1; e_data = q[0].data; end
      end
      e_user  = {at0, !act, hs, vs};
      m_valid = 1;
      m_beat  = (m_beat + 1) % FRAME;
    end
    if (pop) void'(q.pop_front());
    if (pushed) begin
      w.sof = in_axis_tuser; w.data = in_axis_tdata;
      q.push_back(w);
    end
    m_rdy = q.size() < DEPTH;
  endtask

  task automatic check_all();
    logic [BPP+8:0] act_v, exp_v;
    act_v = {out_axis_tvalid, out_axis_tdata, out_axis_tuser, locked, underflow, sof_err, in_axis_tready};
    exp_v = {m_valid, e_data, e_user, m_locked, e_under, e_sof, m_rdy};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL beat_cmp t=%0t: got %h want %h", $time, act_v, exp_v);
    end
    if (underflow) n_under++;
    if (sof_err) n_sof++;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step(input bit rnd_rdy, input int vprob);
    bit pushed;
    in_axis_tvalid  = src_en && ($urandom_range(99) < vprob);
    in_axis_tuser   = (src_idx == 0);
    in_axis_tdata   = src_data;
    out_axis_tready = rnd_rdy ? 1'($urandom_range(1)) : 1'b1;
    @(posedge clk);
    model_edge(pushed);
    if (pushed) begin
      src_idx = (src_idx + 1) % NPIX;
      if (inject_at >= 0 && src_idx == inject_at) begin
        src_idx = 0;
        inject_at = -1;
      end
      src_data = BPP'($urandom);
    end
    nsteps++;
    #1 check_all();
  endtask

  vec_t vecs[11];
  int   guard;

  initial begin
    vecs[0]  = '{0,   4'b1000, 1'b0, '0};
    vecs[1]  = '{7,   4'b0000, 1'b0, '0};
    vecs[2]  = '{8,   4'b0100, 1'b0, '0};
    vecs[3]  = '{10,  4'b0110, 1'b0, '0};
    vecs[4]  = '{12,  4'b0110, 1'b0, '0};
    vecs[5]  = '{13,  4'b0100, 1'b0, '0};
    vecs[6]  = '{15,  4'b0000, 1'b0, '0};
    vecs[7]  = '{60,  4'b0100, 1'b0, '0};
    vecs[8]  = '{75,  4'b0101, 1'b0, '0};
    vecs[9]  = '{85,  4'b0111, 1'b0, '0};
    vecs[10] = '{120, 4'b1000, 1'b0, '0};

    model_reset();
    #1 check_all();
    chk("reset_tvalid", int'(out_axis_tvalid), 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Raster table with no input: every active pixel is 0 and lock never happens.
    for (int i = 0; i < 11; i++) begin
      while (nsteps <= vecs[i].beat) step(1'b0, 100);
      chk($sformatf("vec%0d_tuser", i), int'(out_axis_tuser), int'(vecs[i].user));
      chk($sformatf("vec%0d_locked", i), int'(locked), int'(vecs[i].lck));
      chk($sformatf("vec%0d_tdata", i), int'(out_axis_tdata), int'(vecs[i].data));
    end

    // Input starts mid-frame.
    src_idx = 10; src_data = BPP'($urandom); src_en = 1'b1;
    repeat (4 * FRAME) step(1'b0, 100);
    chk("midstart_locked", int'(locked), 1);

    // Input stall of 40 cycles mid-line while locked.
    guard = 0;
    while (!(m_locked && m_beat == 20) && guard < 2 * FRAME) begin
      step(1'b0, 100);
      guard++;
    end
    chk("gap_wait_timeout", int'(guard < 2 * FRAME), 1);
    n_under = 0;
    src_en = 1'b0;
    repeat (40) step(1'b0, 100);
    chk("gap_unlocked", int'(locked), 0);
    src_en = 1'b1;
    repeat (3 * FRAME) step(1'b0, 100);
    chk("gap_underflow_cnt", n_under, 1);
    chk("gap_relocked", int'(locked), 1);

    // Early SOF injected inside a frame.
    n_sof = 0; n_under = 0;
    inject_at = 13;
    repeat (3 * FRAME) step(1'b0, 100);
    chk("early_sof_cnt", n_sof, 1);
    chk("early_underflow_cnt", n_under, 0);
    chk("early_relocked", int'(locked), 1);

    // Random downstream backpressure and bursty input.
    repeat (8 * FRAME) step(1'b1, 90);
    repeat (4 * FRAME) step(1'b1, 100);

    // Asynchronous reset mid-line.
    #2 resetn = 1'b0;
    model_reset();
    #1 check_all();
    chk("async_rst_outs", int'({out_axis_tvalid, out_axis_tdata, out_axis_tuser, locked, underflow, sof_err}), 0);
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    step(1'b0, 100);
    chk("post_rst_tvalid", int'(out_axis_tvalid), 1);
    chk("post_rst_locked", int'(locked), 0);
    repeat (3 * FRAME) step(1'b0, 100);
    chk("post_rst_relocked", int'(locked), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
